// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl -- load/store unit controller for a 32-bit word-organised memory.
//
// Handles one pipeline access at a time: byte, halfword or word loads
// (sign- or zero-extended) and stores. Sub-word stores are done as a
// read-modify-write of the containing word. Misaligned or illegal-size
// accesses complete immediately with Err set and touch nothing.
//
// Ports
//   CLK, RST_N        clock, asynchronous active-low reset
//   Req, Wr, Size,    access request (sampled only when idle), direction,
//   Sign, Addr, WData size code, load sign-extend, byte address, store data
//   Busy, Done        stall while not idle, one-cycle completion pulse
//   RData, Err        registered load result, misalignment/illegal flag
//   Mem_WE, Mem_Addr, word-memory write enable (memory writes on negedge),
//   Mem_DIn, Mem_DOut word index, write data, combinational read data
// ---------------------------------------------------------------------------
module lsu_ctrl (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Req,
  input  logic        Wr,
  input  logic [1:0]  Size,
  input  logic        Sign,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] RData,
  output logic        Err,
  output logic        Mem_WE,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_DIn,
  input  logic [31:0] Mem_DOut
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] old_q, old_d;      // word read during RMW, merged in WR
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        misaligned_in;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merged_word;

  // Alignment is judged on the request inputs so the accept edge already
  // knows whether to skip the memory phases.
  always_comb begin
    misaligned_in = 1'b0;
    case (Size)
      SZ_BYTE: misaligned_in = 1'b0;
      SZ_HALF: misaligned_in = Addr[0];
      SZ_WORD: misaligned_in = |Addr[1:0];
      default: misaligned_in = 1'b1;
    endcase
  end

  // Lane extraction from the addressed memory word for loads.
  always_comb begin
    lane_b   = Mem_DOut[{addr_q[1:0], 3'b000} +: 8];
    lane_h   = Mem_DOut[{addr_q[1], 4'b0000} +: 16];
    load_val = Mem_DOut;
    case (size_q)
      SZ_BYTE: load_val = {{24{sign_q & lane_b[7]}}, lane_b};
      SZ_HALF: load_val = {{16{sign_q & lane_h[15]}}, lane_h};
      default: load_val = Mem_DOut;
    endcase
  end

  // Store word: the old word with the selected lane(s) replaced. For word
  // stores the whole word is replaced, so old_q is irrelevant there.
  always_comb begin
    merged_word = old_q;
    case (size_q)
      SZ_BYTE: merged_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      SZ_HALF: merged_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged_word = wdata_q;
    endcase
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    sign_d  = sign_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    old_d   = old_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (Req) begin
          wr_d    = Wr;
          size_d  = Size;
          sign_d  = Sign;
          addr_d  = Addr;
          wdata_d = WData;
          err_d   = misaligned_in;
          if (misaligned_in)        state_d = S_RESP;
          else if (!Wr)             state_d = S_RD;
          else if (Size == SZ_WORD) state_d = S_WR;
          else                      state_d = S_RD;  // sub-word store: RMW
        end
      end
      S_RD: begin
        if (wr_q) begin
          old_d   = Mem_DOut;
          state_d = S_WR;
        end else begin
          rdata_d = load_val;
          state_d = S_RESP;
        end
      end
      S_WR:   state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      old_q   <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs are decoded from the state register so an asynchronous reset
  // drops Mem_WE immediately, before the memory's negedge write.
  assign Busy     = (state_q != S_IDLE);
  assign Done     = (state_q == S_RESP);
  assign Mem_WE   = (state_q == S_WR);
  assign Mem_Addr = (state_q == S_IDLE) ? 32'd0 : {2'b00, addr_q[31:2]};
  assign Mem_DIn  = (state_q == S_WR) ? merged_word : 32'd0;
  assign RData    = rdata_q;
  assign Err      = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl -- self-checking bench for lsu_ctrl.
// A 64-word memory (word i preloaded with i) is attached to the DUT; a
// separate reference copy plus arithmetic lane rules predict every result.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        Req;
  logic        Wr;
  logic [1:0]  Size;
  logic        Sign;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic        Busy;
  logic        Done;
  logic [31:0] RData;
  logic        Err;
  logic        Mem_WE;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_DIn;
  logic [31:0] Mem_DOut;

  int n_checks = 0;
  int n_errors = 0;
  int txn_no   = 0;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  bit          mem_loaded = 1'b0;
  logic [31:0] rdata_exp;
  logic        last_err;

  always #5 CLK = ~CLK;

  lsu_ctrl dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .Req      (Req),
    .Wr       (Wr),
    .Size     (Size),
    .Sign     (Sign),
    .Addr     (Addr),
    .WData    (WData),
    .Busy     (Busy),
    .Done     (Done),
    .RData    (RData),
    .Err      (Err),
    .Mem_WE   (Mem_WE),
    .Mem_Addr (Mem_Addr),
    .Mem_DIn  (Mem_DIn),
    .Mem_DOut (Mem_DOut)
  );

  // Word memory: combinational read, write on the falling edge.
  assign Mem_DOut = mem[Mem_Addr[5:0]];
  always @(negedge CLK) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= i;
      mem_loaded <= 1'b1;
    end else if (Mem_WE) begin
      mem[Mem_Addr[5:0]] <= Mem_DIn;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete access. Called at #1 after a posedge with the DUT idle;
  // returns at #1 after a posedge with the DUT idle again.
  task automatic do_txn(input logic wr, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic        mis;
    int          idx, lat_exp, we_cycle_exp, we_cnt_exp;
    int          n, we_cnt, we_cycle;
    logic [31:0] old, neww, lane;
    bit          seen_done;

    mis = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    idx  = int'(addr[7:2]);
    old  = ref_mem[idx];
    neww = old;
    if (!mis && wr) begin
      case (size)
        2'd0: neww = (old & ~(32'hFF << (8 * addr[1:0]))) | ((wdata & 32'hFF) << (8 * addr[1:0]));
        2'd1: neww = (old & ~(32'hFFFF << (16 * addr[1]))) | ((wdata & 32'hFFFF) << (16 * addr[1]));
        default: neww = wdata;
      endcase
    end
    if (!mis && !wr) begin
      case (size)
        2'd0: begin
          lane = (old >> (8 * addr[1:0])) & 32'hFF;
          if (sign && lane[7]) lane = lane | 32'hFFFF_FF00;
        end
        2'd1: begin
          lane = (old >> (16 * addr[1])) & 32'hFFFF;
          if (sign && lane[15]) lane = lane | 32'hFFFF_0000;
        end
        default: lane = old;
      endcase
      rdata_exp = lane;
    end
    lat_exp      = mis ? 1 : (!wr ? 2 : (size == 2'd2 ? 2 : 3));
    we_cnt_exp   = (mis || !wr) ? 0 : 1;
    we_cycle_exp = (mis || !wr) ? 0 : (size == 2'd2 ? 1 : 2);

    check("idle_busy", {31'd0, Busy}, 32'd0);
    check("idle_maddr", Mem_Addr, 32'd0);
    check("idle_mdin", Mem_DIn, 32'd0);
    check("err_hold", {31'd0, Err}, {31'd0, last_err});

    Req = 1'b1; Wr = wr; Size = size; Sign = sign; Addr = addr; WData = wdata;
    @(posedge CLK); #1;
    // Scramble request inputs: the DUT must work from its latched copy.
    Req = 1'b0; Wr = 1'($urandom); Size = 2'($urandom); Sign = 1'($urandom);
    Addr = $urandom; WData = $urandom;

    n = 1; we_cnt = 0; we_cycle = 0; seen_done = 0;
    while (!seen_done && n <= 6) begin
      if (Done) begin
        seen_done = 1;
      end else begin
        check("busy", {31'd0, Busy}, 32'd1);
        check("maddr", Mem_Addr, addr >> 2);
        if (Mem_WE) begin
          we_cnt++;
          we_cycle = n;
          check("mdin", Mem_DIn, neww);
        end
        @(posedge CLK); #1;
        n++;
      end
    end
    check("latency", n, lat_exp);
    check("resp_busy", {31'd0, Busy}, 32'd1);
    check("resp_maddr", Mem_Addr, addr >> 2);
    check("err", {31'd0, Err}, {31'd0, mis});
    check("rdata", RData, rdata_exp);
    check("we_count", we_cnt, we_cnt_exp);
    check("we_cycle", we_cycle, we_cycle_exp);
    @(posedge CLK); #1;
    check("done_pulse", {31'd0, Done}, 32'd0);
    check("busy_end", {31'd0, Busy}, 32'd0);
    if (!mis && wr) ref_mem[idx] = neww;
    check("mem_word", mem[idx], ref_mem[idx]);
    last_err = mis;
    txn_no++;
    $display("txn %0d: wr=%0d size=%0d sign=%0d addr=0x%08h wdata=0x%08h rdata=0x%08h err=%0d lat=%0d",
             txn_no, wr, size, sign, addr, wdata, RData, Err, n);
  endtask

  initial begin
    int acc, dones, exp_acc;
    logic prev_busy;
    logic [31:0] wd;

    for (int i = 0; i < 64; i++) ref_mem[i] = i;
    rdata_exp = 32'd0;
    last_err  = 1'b0;
    RST_N = 1'b0; Req = 1'b0; Wr = 1'b0; Size = 2'd0; Sign = 1'b0;
    Addr = 32'd0; WData = 32'd0;

    // Reset state
    @(posedge CLK); #1;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_err", {31'd0, Err}, 32'd0);
    check("rst_we", {31'd0, Mem_WE}, 32'd0);
    check("rst_rdata", RData, 32'd0);
    check("rst_maddr", Mem_Addr, 32'd0);
    check("rst_mdin", Mem_DIn, 32'd0);
    @(negedge CLK); RST_N = 1'b1; #1;

    // Directed: first accept on the first posedge out of reset
    do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    check("req033_rdata", RData, 32'h0000_0004);
    do_txn(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344);
    do_txn(1'b1, 2'd0, 1'b0, 32'h22, 32'h0000_00AB);
    check("req034_word", mem[8], 32'h11AB_3344);
    do_txn(1'b0, 2'd0, 1'b1, 32'h22, 32'd0);
    check("req035_sb", RData, 32'hFFFF_FFAB);
    do_txn(1'b0, 2'd0, 1'b0, 32'h22, 32'd0);
    check("req035_ub", RData, 32'h0000_00AB);
    do_txn(1'b0, 2'd1, 1'b1, 32'h22, 32'd0);
    check("req035_sh", RData, 32'h0000_11AB);
    do_txn(1'b1, 2'd2, 1'b0, 32'h21, 32'hDEAD_BEEF);
    check("req036_word", mem[8], 32'h11AB_3344);
    do_txn(1'b1, 2'd1, 1'b0, 32'h32, 32'hFFFF_8001);  // halfword RMW
    do_txn(1'b0, 2'd3, 1'b0, 32'h30, 32'd0);          // illegal size

    // Reset asserted in WR ahead of the memory's negedge write
    wd = $urandom;
    Req = 1'b1; Wr = 1'b1; Size = 2'd2; Sign = 1'b0; Addr = 32'h3C; WData = wd;
    @(posedge CLK); #1;
    Req = 1'b0;
    check("rst_wr_we_pre", {31'd0, Mem_WE}, 32'd1);
    #1 RST_N = 1'b0;
    #1;
    check("rst_wr_we", {31'd0, Mem_WE}, 32'd0);
    check("rst_wr_busy", {31'd0, Busy}, 32'd0);
    check("rst_wr_done", {31'd0, Done}, 32'd0);
    check("rst_wr_maddr", Mem_Addr, 32'd0);
    check("rst_wr_rdata", RData, 32'd0);
    rdata_exp = 32'd0;
    last_err  = 1'b0;
    @(negedge CLK); #1;
    check("rst_wr_mem", mem[15], ref_mem[15]);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    $display("txn reset-in-WR: addr=0x0000003c wdata=0x%08h mem=0x%08h", wd, mem[15]);
    do_txn(1'b0, 2'd2, 1'b0, 32'h3C, 32'd0);

    // Req held high for 10 cycles: a load spends RD, RESP, then one idle
    // cycle before the next accept, so one accept every 3 cycles.
    rdata_exp = ref_mem[4];
    exp_acc = (10 + 2) / 3;
    acc = 0; dones = 0; prev_busy = Busy;
    Req = 1'b1; Wr = 1'b0; Size = 2'd2; Sign = 1'b0; Addr = 32'h10;
    for (int i = 0; i < 15; i++) begin
      @(posedge CLK); #1;
      if (i == 9) Req = 1'b0;
      if (Busy && !prev_busy) acc++;
      if (Done) begin
        dones++;
        check("hold_rdata", RData, rdata_exp);
      end
      prev_busy = Busy;
    end
    check("hold_accepts", acc, exp_acc);
    check("hold_dones", dones, exp_acc);
    check("hold_idle", {31'd0, Busy}, 32'd0);
    $display("txn hold: accepts=%0d dones=%0d", acc, dones);
    last_err = 1'b0;

    // Randomized accesses
    for (int t = 0; t < 40; t++) begin
      do_txn(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 255)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameters: none; data path fixed at 32 bits, byte-addressed, little-endian.
REQ-002 CLK  in  1  single clock; all state on posedge CLK.
REQ-003 RST_N  in  1  reset; asynchronous, active-low.
REQ-004 Req  in  1  pipeline access request, sampled only in IDLE.
REQ-005 Wr  in  1  1 = store, 0 = load.
REQ-006 Size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 Sign  in  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-008 Addr  in  32  byte address.
REQ-009 WData  in  32  store data, right-justified.
REQ-010 Busy  out  1  stall to pipeline; 1 whenever state != IDLE.
REQ-011 Done  out  1  one-cycle completion pulse.
REQ-012 RData  out  32  registered load result, held until next load completes.
REQ-013 Err  out  1  misaligned/illegal flag, registered, valid with Done, held until next accept.
REQ-014 Mem_WE  out  1  word-memory write enable; the memory writes on negedge CLK.
REQ-015 Mem_Addr  out  32  word index = latched Addr[31:2], zero-extended.
REQ-016 Mem_DIn  out  32  word write data.
REQ-017 Mem_DOut  in  32  word read data, combinational from Mem_Addr.

Function
REQ-018 States: IDLE, RD, WR, RESP; Mem_WE = 1 only in WR, decoded from state.
REQ-019 Accept: IDLE and Req=1 at posedge -> latch Wr, Size, Sign, Addr, WData; clear Err.
REQ-020 Req while Busy is ignored; no queueing; next accept only from IDLE.
REQ-021 Misaligned: Size=01 with Addr[0]=1, Size=10 with Addr[1:0]!=0, or Size=11 -> IDLE->RESP, Err=1, no memory write, RData unchanged.
REQ-022 Load: IDLE->RD->RESP->IDLE; Mem_DOut captured at end of RD; Done in RESP, 2 cycles after accept edge.
REQ-023 Word store: IDLE->WR->RESP->IDLE; Mem_DIn = WData.
REQ-024 Sub-word store (read-modify-write): IDLE->RD->WR->RESP->IDLE; RD captures old word; WR drives old word with selected lane(s) replaced.
REQ-025 Lanes: byte k = Addr[1:0] occupies bits 8k+7:8k; halfword h = Addr[1] occupies bits 16h+15:16h; only WData low byte/half used.
REQ-026 Load extraction: selected lane right-justified; upper bits from lane MSB if Sign=1, else 0; Size=10 passes word unchanged.
REQ-027 Mem_Addr stable from accept through RESP; Mem_Addr = 0 and Mem_DIn = 0 in IDLE.
REQ-028 Done = 1 exactly in RESP; Busy = 0 in IDLE only, so Done and Busy coincide in RESP.
REQ-029 Stores leave RData unchanged.

Reset
REQ-030 RST_N=0 forces state IDLE immediately; Busy, Done, Err, Mem_WE = 0; RData, Mem_Addr, Mem_DIn = 0.
REQ-031 Reset during WR deasserts Mem_WE asynchronously; if before the negedge, the memory word is not written.
REQ-032 First accept allowed at first posedge with RST_N=1.

Verification (bench memory model: word i preloaded with value i)
REQ-033 Load word Addr=0x10 -> Mem_Addr=4, Done 2 cycles after accept, RData=0x00000004, Err=0.
REQ-034 Store word 0x11223344 at Addr 0x20, then store byte 0xAB at Addr 0x22 -> word 8 = 0x11AB3344; RD precedes WR; Done 3 cycles after accept.
REQ-035 Then load byte Addr 0x22: Sign=1 -> RData=0xFFFFFFAB; Sign=0 -> 0x000000AB; load half Addr 0x22, Sign=1 -> 0x000011AB.
REQ-036 Store word at Addr 0x21 -> Done 1 cycle after accept, Err=1, Mem_WE never 1, word 8 unchanged.
REQ-037 Reset pulse in WR before negedge -> Mem_WE and Busy drop at once, state IDLE, target word unchanged; next load returns correct data.
REQ-038 Req held high for 10 cycles -> transactions accepted only from IDLE; one Done per accept; no overlap.
